// File: rtl/axi_burst_arbiter.sv
// axi_burst_arbiter: shares one DDR read port and one DDR write port between
// two burst readers and two burst writers. One burst is in flight at a time;
// winners are picked round-robin (rd0, rd1, wr0, wr1) and a watchdog aborts
// bursts that never see their finish.
module axi_burst_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  // readers
  input  logic              rd0_req,
  input  logic [7:0]        rd0_len,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_data_valid,
  output logic              rd0_finish,
  input  logic              rd1_req,
  input  logic [7:0]        rd1_len,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_data_valid,
  output logic              rd1_finish,
  output logic [DATA_W-1:0] rd_data_o,
  // writers
  input  logic              wr0_req,
  input  logic [7:0]        wr0_len,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_data_req,
  output logic              wr0_finish,
  input  logic              wr1_req,
  input  logic [7:0]        wr1_len,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_data_req,
  output logic              wr1_finish,
  // DDR controller read side
  output logic              rd_burst_req,
  output logic [7:0]        rd_burst_len,
  output logic [ADDR_W-1:0] rd_burst_addr,
  input  logic              rd_burst_data_valid,
  input  logic [DATA_W-1:0] rd_burst_data,
  input  logic              rd_burst_finish,
  // DDR controller write side
  output logic              wr_burst_req,
  output logic [7:0]        wr_burst_len,
  output logic [ADDR_W-1:0] wr_burst_addr,
  output logic [DATA_W-1:0] wr_burst_data,
  input  logic              wr_burst_data_req,
  input  logic              wr_burst_finish,
  // status
  output logic [1:0]        grant_id,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  // grant_r holds the owner during ISSUE/BUSY and, because it is only reloaded
  // when a new winner is picked, it doubles as last_grant everywhere else.
  logic [1:0]          grant_r;
  logic [7:0]          len_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                rd_req_r;
  logic                wr_req_r;
  logic [WD_W-1:0]     wdog_r;
  logic                err_r;

  logic [3:0]          req_vec_s;
  logic [1:0]          cand_s;
  logic [1:0]          winner_s;
  logic                win_valid_s;
  logic [7:0]          win_len_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic                busy_s;
  logic                fin_match_s;
  logic                timeout_s;
  logic                end_s;

  assign req_vec_s = {wr1_req, wr0_req, rd1_req, rd0_req};
  assign busy_s    = (state_r == ST_ISSUE) || (state_r == ST_BUSY);

  // Round-robin search starting one past the last grant, wrapping 3 -> 0.
  always_comb begin
    cand_s      = grant_r;
    winner_s    = grant_r;
    win_valid_s = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand_s = grant_r + 2'(i);
      if (!win_valid_s && req_vec_s[cand_s]) begin
        winner_s    = cand_s;
        win_valid_s = 1'b1;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // Select the winning requester's burst length and start address.
  always_comb begin
    win_len_s  = 8'd0;
    win_addr_s = '0;
    case (winner_s)
      2'd0:    begin win_len_s = rd0_len; win_addr_s = rd0_addr; end
      2'd1:    begin win_len_s = rd1_len; win_addr_s = rd1_addr; end
      2'd2:    begin win_len_s = wr0_len; win_addr_s = wr0_addr; end
      2'd3:    begin win_len_s = wr1_len; win_addr_s = wr1_addr; end
      default: begin win_len_s = 8'd0;    win_addr_s = '0;       end
    endcase
  end

  // Burst termination: matching finish only counts in BUSY; a finish wins a tie with the watchdog.
  always_comb begin
    fin_match_s = 1'b0;
    if (state_r == ST_BUSY) begin
      fin_match_s = grant_r[1] ? wr_burst_finish : rd_burst_finish;
    end else begin
      fin_match_s = 1'b0;
    end
    timeout_s = busy_s && (wdog_r == WD_LAST) && !fin_match_s;
    end_s     = fin_match_s || timeout_s;
  end

  // Next-state logic for the IDLE -> ISSUE -> BUSY -> GAP cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = win_valid_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt_s = end_s ? ST_GAP : ST_BUSY;
      ST_BUSY:  state_nxt_s = end_s ? ST_GAP : ST_BUSY;
      ST_GAP:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch winner, its len/addr and the downstream request; drop the request on burst end.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      grant_r  <= 2'd3;
      len_r    <= 8'd0;
      addr_r   <= '0;
      rd_req_r <= 1'b0;
      wr_req_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && win_valid_s) begin
      grant_r  <= winner_s;
      len_r    <= win_len_s;
      addr_r   <= win_addr_s;
      rd_req_r <= ~winner_s[1];
      wr_req_r <= winner_s[1];
    end else if (end_s) begin
      rd_req_r <= 1'b0;
      wr_req_r <= 1'b0;
    end
  end

  // Watchdog: counts cycles spent in ISSUE/BUSY, cleared whenever a burst ends or is idle.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wdog_r <= '0;
    end else if (busy_s && !end_s) begin
      wdog_r <= wdog_r + WD_W'(1);
    end else begin
      wdog_r <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end
  end

  // Combinational routing of strobes, finish pulses and write data to the current owner.
  always_comb begin
    rd0_data_valid = busy_s && (grant_r == 2'd0) && rd_burst_data_valid;
    rd1_data_valid = busy_s && (grant_r == 2'd1) && rd_burst_data_valid;
    wr0_data_req   = busy_s && (grant_r == 2'd2) && wr_burst_data_req;
    wr1_data_req   = busy_s && (grant_r == 2'd3) && wr_burst_data_req;
    rd0_finish     = end_s && (grant_r == 2'd0);
    rd1_finish     = end_s && (grant_r == 2'd1);
    wr0_finish     = end_s && (grant_r == 2'd2);
    wr1_finish     = end_s && (grant_r == 2'd3);
    wr_burst_data  = '0;
    if (busy_s && (grant_r == 2'd2)) begin
      wr_burst_data = wr0_data;
    end else if (busy_s && (grant_r == 2'd3)) begin
      wr_burst_data = wr1_data;
    end else begin
      wr_burst_data = '0;
    end
  end

  assign rd_data_o     = rd_burst_data;
  assign rd_burst_req  = rd_req_r;
  assign rd_burst_len  = len_r;
  assign rd_burst_addr = addr_r;
  assign wr_burst_req  = wr_req_r;
  assign wr_burst_len  = len_r;
  assign wr_burst_addr = addr_r;
  assign grant_id      = grant_r;
  assign err_timeout   = err_r;

endmodule
